// File: rtl/glm_c0_read_arbiter_pkg.sv
// CCI-P c0 channel types used by the c0 read arbiter.
// A reduced copy of the shell's ccip_if_pkg definitions for the c0 Tx/Rx paths.
package glm_c0_read_arbiter_pkg;

  localparam int unsigned CCIP_CLADDR_WIDTH = 42;
  localparam int unsigned CCIP_MDATA_WIDTH  = 16;
  localparam int unsigned CCIP_CLDATA_WIDTH = 512;

  typedef logic [CCIP_CLADDR_WIDTH-1:0] t_ccip_clAddr;
  typedef logic [CCIP_MDATA_WIDTH-1:0]  t_ccip_mdata;
  typedef logic [CCIP_CLDATA_WIDTH-1:0] t_ccip_clData;

  typedef enum logic [3:0] {
    eREQ_RDLINE_I = 4'h0,
    eREQ_RDLINE_S = 4'h1
  } t_ccip_c0_req;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef struct packed {
    logic [1:0]   vc_sel;
    logic [1:0]   rsvd1;
    logic [1:0]   cl_len;
    t_ccip_c0_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    logic [1:0]   vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic [1:0]   rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

endpackage

// File: rtl/glm_c0_read_arbiter_if.sv
// Requester-side bundle of the c0 read arbiter: line requests, grants,
// routed responses and per-requester in-flight counts.
interface glm_c0_read_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*42-1:0] req_addr;
  logic [NUM_REQ-1:0]    req_grant;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [511:0]          rsp_data;
  logic [NUM_REQ*8-1:0]  outstanding;

  // load engines
  modport master (
    output req_valid, req_addr,
    input  req_grant, rsp_valid, rsp_data, outstanding
  );

  // arbiter
  modport slave (
    input  req_valid, req_addr,
    output req_grant, rsp_valid, rsp_data, outstanding
  );
endinterface

// File: rtl/glm_c0_read_arbiter.sv
// Round-robin arbiter sharing the CCI-P c0 read channel among NUM_REQ load engines,
// with mdata tagging, response routing and per-requester credit. Optional
// statistics counters are built when GLM_C0_ARB_STATS_EN is defined.
module glm_c0_read_arbiter
  import glm_c0_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned LOG2_NUM_REQ    = 2,
  parameter int unsigned MAX_OUTSTANDING = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  glm_c0_read_arbiter_if.slave   bus,
  input  logic                   c0TxAlmFull,
  output t_if_ccip_c0_Tx         af2cp_sTx_c0,
  input  t_if_ccip_c0_Rx         cp2af_sRx_c0
`ifdef GLM_C0_ARB_STATS_EN
  ,
  input  logic                   stat_clear,
  output logic [NUM_REQ*32-1:0]  stat_grants,
  output logic [31:0]            stat_stall_cycles
`endif
);

  localparam int unsigned IW = LOG2_NUM_REQ;
  localparam int unsigned CW = 8;
  localparam int unsigned AW = CCIP_CLADDR_WIDTH;
  localparam int unsigned SW = 32;

  logic [NUM_REQ-1:0] elig_c;
  logic [NUM_REQ-1:0] grant_c;
  logic [NUM_REQ-1:0] dec_c;
  logic [NUM_REQ-1:0] underflow_c;
  logic               grant_any_c;
  logic [IW-1:0]      grant_idx_c;
  logic [IW-1:0]      scan_idx_c;
  logic [IW-1:0]      ptr_q;
  logic [CW-1:0]      cnt_q [NUM_REQ];
  logic [CW-1:0]      cnt_d [NUM_REQ];
  t_ccip_clAddr       addr_c [NUM_REQ];
  logic               rd_rsp_c;
  logic               route_c;
  logic [IW-1:0]      tag_c;
  logic [NUM_REQ-1:0] rsp_valid_q;
  t_ccip_clData       rsp_data_q;
  logic               unused_rx;

  // Per-requester address slices and credit-qualified eligibility
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_c[i] = bus.req_addr[AW*i +: AW];
      elig_c[i] = bus.req_valid[i] && (cnt_q[i] < CW'(MAX_OUTSTANDING));
    end
  end

  // Round-robin search starting at ptr_q; suppressed by almost-full and reset
  always_comb begin
    grant_any_c = 1'b0;
    grant_idx_c = '0;
    scan_idx_c  = '0;
    grant_c     = '0;
    if (reset && !c0TxAlmFull) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx_c = IW'((32'(ptr_q) + 32'(k)) % 32'(NUM_REQ));
        if (!grant_any_c && elig_c[scan_idx_c]) begin
          grant_any_c = 1'b1;
          grant_idx_c = scan_idx_c;
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_c[i] = grant_any_c && (grant_idx_c == IW'(i));
    end
  end

  // Read-response decode: only RDLINE responses with an in-range tag are routed
  always_comb begin
    rd_rsp_c = cp2af_sRx_c0.rspValid && (cp2af_sRx_c0.hdr.resp_type == eRSP_RDLINE);
    tag_c    = cp2af_sRx_c0.hdr.mdata[IW-1:0];
    route_c  = rd_rsp_c && (32'(tag_c) < 32'(NUM_REQ));
    for (int i = 0; i < NUM_REQ; i++) begin
      dec_c[i] = route_c && (tag_c == IW'(i));
    end
  end

  // In-flight counters: a grant and a response on the same requester cancel
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i]       = cnt_q[i];
      underflow_c[i] = dec_c[i] && !grant_c[i] && (cnt_q[i] == '0);
      if (grant_c[i] && !dec_c[i]) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (dec_c[i] && !grant_c[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q        <= '0;
      af2cp_sTx_c0 <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      if (grant_any_c) begin
        ptr_q <= IW'((32'(grant_idx_c) + 32'd1) % 32'(NUM_REQ));
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      af2cp_sTx_c0 <= '0;
      if (grant_any_c) begin
        af2cp_sTx_c0.valid         <= 1'b1;
        af2cp_sTx_c0.hdr.address   <= addr_c[grant_idx_c];
        af2cp_sTx_c0.hdr.mdata     <= CCIP_MDATA_WIDTH'(grant_idx_c);
      end
      rsp_valid_q <= dec_c;
      if (route_c) begin
        rsp_data_q <= cp2af_sRx_c0.data;
      end
    end
  end

  assign bus.req_grant = grant_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.outstanding[CW*i +: CW] = cnt_q[i];
    end
  end

  // Header fields other than resp_type/mdata and the MMIO strobes carry nothing here
  assign unused_rx = ^{cp2af_sRx_c0.hdr, cp2af_sRx_c0.mmioRdValid, cp2af_sRx_c0.mmioWrValid};

`ifdef GLM_C0_ARB_STATS_EN
  logic [SW-1:0] grant_cnt_q [NUM_REQ];
  logic [SW-1:0] stall_cnt_q;

  // Saturating per-requester grant counts and no-grant stall cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt_q[i] <= '0;
      end
    end else if (stat_clear) begin
      stall_cnt_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_c[i] && (grant_cnt_q[i] != '1)) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + SW'(1);
        end
      end
      if ((|bus.req_valid) && !grant_any_c && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + SW'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_grants[SW*i +: SW] = grant_cnt_q[i];
    end
  end

  assign stat_stall_cycles = stall_cnt_q;
`endif

  // A routed response for a requester with nothing in flight is a protocol error
  assert property (@(posedge clk) disable iff (!reset) underflow_c == '0);

endmodule

// File: tb/tb_glm_c0_read_arbiter.sv
// Self-checking bench for glm_c0_read_arbiter: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the arbiter.
module tb_glm_c0_read_arbiter;
  import glm_c0_read_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int LN  = 2;
  localparam int MAX = 6;

  logic           clk;
  logic           reset;
  logic           alm;
  t_if_ccip_c0_Tx tx;
  t_if_ccip_c0_Rx rx;

  glm_c0_read_arbiter_if #(.NUM_REQ(N)) bus ();

  glm_c0_read_arbiter #(
    .NUM_REQ(N), .LOG2_NUM_REQ(LN), .MAX_OUTSTANDING(MAX)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .c0TxAlmFull(alm),
    .af2cp_sTx_c0(tx), .cp2af_sRx_c0(rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // Behavioural model state
  int                 m_ptr;
  int                 m_cnt [N];
  logic               m_tx_valid;
  t_ccip_c0_ReqMemHdr m_tx_hdr;
  logic [N-1:0]       m_rsp_valid;
  logic [511:0]       m_rsp_data;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[32*k +: 32] = $urandom();
    return v;
  endfunction

  // Compare process: outputs vs model, then model advances on this cycle's inputs
  always @(negedge clk) begin
    int g;
    int j;
    logic [N-1:0] gv;
    if (!reset) begin
      check("rst_tx_valid", tx.valid, 0);
      check("rst_tx_hdr", tx.hdr, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_data", bus.rsp_data, 0);
      check("rst_outstanding", bus.outstanding, 0);
      check("rst_req_grant", bus.req_grant, 0);
      m_ptr = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_tx_valid  = 1'b0;
      m_tx_hdr    = '0;
      m_rsp_valid = '0;
      m_rsp_data  = '0;
    end else begin
      check("tx_valid", tx.valid, m_tx_valid);
      check("tx_hdr", tx.hdr, m_tx_hdr);
      check("rsp_valid", bus.rsp_valid, m_rsp_valid);
      if (m_rsp_valid != 0) check("rsp_data", bus.rsp_data, m_rsp_data);
      for (int i = 0; i < N; i++) check("outstanding", bus.outstanding[8*i +: 8], m_cnt[i]);
      g = -1;
      if (!alm) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (g < 0 && bus.req_valid[j] && m_cnt[j] < MAX) g = j;
        end
      end
      gv = '0;
      if (g >= 0) gv[g] = 1'b1;
      check("req_grant", bus.req_grant, gv);
      m_tx_valid = (g >= 0);
      m_tx_hdr   = '0;
      if (g >= 0) begin
        m_tx_hdr.address = bus.req_addr[42*g +: 42];
        m_tx_hdr.mdata   = 16'(g);
        m_cnt[g]++;
        m_ptr = (g + 1) % N;
      end
      m_rsp_valid = '0;
      if (rx.rspValid && rx.hdr.resp_type == eRSP_RDLINE) begin
        j = int'(rx.hdr.mdata) % (1 << LN);
        if (j < N) begin
          m_rsp_valid[j] = 1'b1;
          m_rsp_data     = rx.data;
          if (m_cnt[j] > 0) m_cnt[j]--;
        end
      end
    end
  end

  task automatic drive(input logic [N-1:0] vld, input logic a, input logic rv,
                       input logic [3:0] rtype, input logic [15:0] md, input logic [511:0] data);
    @(posedge clk); #1;
    bus.req_valid = vld;
    alm = a;
    for (int i = 0; i < N; i++) bus.req_addr[42*i +: 42] = 42'({$urandom(), $urandom()});
    rx = '0;
    rx.rspValid       = rv;
    rx.hdr.resp_type  = t_ccip_c0_rsp'(rtype);
    rx.hdr.mdata      = md;
    rx.hdr.vc_used    = 2'($urandom());
    rx.hdr.cl_num     = 2'($urandom());
    rx.data           = data;
    #1;
  endtask

  task automatic idle(input logic [N-1:0] vld, input logic a);
    drive(vld, a, 1'b0, 4'h0, 16'h0, '0);
  endtask

  task automatic rsp(input logic [N-1:0] vld, input int tag, input logic [511:0] data);
    drive(vld, 1'b0, 1'b1, 4'h0, 16'(tag), data);
  endtask

  task automatic drain();
    int j;
    for (int guard = 0; guard < 100; guard++) begin
      @(negedge clk); #1;
      j = -1;
      for (int i = 0; i < N; i++) if (j < 0 && m_cnt[i] > 0) j = i;
      if (j < 0) break;
      rsp('0, j, rand_line());
    end
    idle('0, 1'b0);
    check("drain_outstanding", bus.outstanding, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ngr;
    int ntx;
    int sum;
    int j;
    logic [511:0] da, db, dc, dd;
    logic [N-1:0] vld;
    logic a, rv;
    logic [3:0] rt;
    logic [15:0] md;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    alm = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    rx = '0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("lit_reset_tx_valid", tx.valid, 0);
    check("lit_reset_outstanding", bus.outstanding, 0);
    @(posedge clk); #1 reset = 1'b1;

    // Round robin with everybody requesting
    for (int c = 0; c < 8; c++) begin
      idle(4'hF, 1'b0);
      check("lit_rr_grant", bus.req_grant, 4'b0001 << (c % 4));
      if (c > 0) begin
        check("lit_rr_tx_valid", tx.valid, 1);
        check("lit_rr_mdata", tx.hdr.mdata, 16'((c - 1) % 4));
      end
    end
    idle('0, 1'b0);
    check("lit_rr_mdata_last", tx.hdr.mdata, 16'd3);
    drain();

    // Single requester runs out of credit, one response reopens it
    ngr = 0;
    for (int c = 0; c < MAX + 2; c++) begin
      idle(4'b0100, 1'b0);
      ngr += int'(bus.req_grant[2]);
    end
    check("lit_credit_grants", ngr, MAX);
    check("lit_credit_count", bus.outstanding[16 +: 8], MAX);
    check("lit_credit_blocked", bus.req_grant, 0);
    rsp(4'b0100, 2, rand_line());
    check("lit_credit_still_blocked", bus.req_grant, 0);
    idle(4'b0100, 1'b0);
    check("lit_credit_regrant", bus.req_grant, 4'b0100);
    check("lit_credit_count_dec", bus.outstanding[16 +: 8], MAX - 1);
    idle('0, 1'b0);
    drain();

    // Almost-full stall: only the already-registered request issues
    idle(4'hF, 1'b0);
    ntx = 0;
    ngr = 0;
    for (int c = 0; c < 5; c++) begin
      idle(4'hF, 1'b1);
      ntx += int'(tx.valid);
      ngr += (bus.req_grant != 0) ? 1 : 0;
      if (c == 0) check("lit_alm_first_tx", tx.valid, 1);
    end
    check("lit_alm_tx_count", ntx, 1);
    check("lit_alm_grants", ngr, 0);
    idle('0, 1'b0);
    drain();

    // Response routing order 3,0,1 then a UMsg that must be ignored
    for (int c = 0; c < 4; c++) idle(4'hF, 1'b0);
    idle('0, 1'b0);
    da = rand_line();
    db = rand_line();
    dc = rand_line();
    rsp('0, 3, da);
    rsp('0, 0, db);
    check("lit_route_a_valid", bus.rsp_valid, 4'b1000);
    check("lit_route_a_data", bus.rsp_data, da);
    rsp('0, 1, dc);
    check("lit_route_b_valid", bus.rsp_valid, 4'b0001);
    check("lit_route_b_data", bus.rsp_data, db);
    drive('0, 1'b0, 1'b1, 4'h4, 16'd2, rand_line());
    check("lit_route_c_valid", bus.rsp_valid, 4'b0010);
    check("lit_route_c_data", bus.rsp_data, dc);
    idle('0, 1'b0);
    check("lit_umsg_ignored", bus.rsp_valid, 0);
    check("lit_umsg_count", bus.outstanding[16 +: 8], 1);
    drain();

    // Grant and response on the same requester in one cycle
    for (int c = 0; c < 5; c++) idle(4'b0010, 1'b0);
    idle('0, 1'b0);
    check("lit_same_pre", bus.outstanding[8 +: 8], 5);
    dd = rand_line();
    rsp(4'b0010, 1, dd);
    check("lit_same_grant", bus.req_grant, 4'b0010);
    idle('0, 1'b0);
    check("lit_same_count", bus.outstanding[8 +: 8], 5);
    check("lit_same_rsp_valid", bus.rsp_valid, 4'b0010);
    check("lit_same_rsp_data", bus.rsp_data, dd);
    drain();

    // Asynchronous reset with lines in flight
    for (int c = 0; c < 11; c++) idle(4'hF, 1'b0);
    sum = 0;
    for (int i = 0; i < N; i++) sum += int'(bus.outstanding[8*i +: 8]);
    check("lit_burst_inflight", sum, 10);
    #1 reset = 1'b0;
    #1;
    check("lit_async_tx_valid", tx.valid, 0);
    check("lit_async_tx_hdr", tx.hdr, 0);
    check("lit_async_outstanding", bus.outstanding, 0);
    check("lit_async_grant", bus.req_grant, 0);
    check("lit_async_rsp_data", bus.rsp_data, 0);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    check("lit_post_reset_grant", bus.req_grant, 4'b0001);
    idle('0, 1'b0);
    drain();

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      @(negedge clk); #1;
      vld = 4'($urandom());
      a   = ($urandom() % 5) == 0;
      rv  = 1'b0;
      rt  = 4'h0;
      md  = 16'h0;
      j   = int'($urandom() % 10);
      if (j < 5) begin
        int s;
        int pick;
        s = int'($urandom() % N);
        pick = -1;
        for (int k = 0; k < N; k++) if (pick < 0 && m_cnt[(s + k) % N] > 0) pick = (s + k) % N;
        if (pick >= 0) begin
          rv = 1'b1;
          md = {14'($urandom()), 2'(pick)};
        end
      end else if (j == 5) begin
        rv = 1'b1;
        rt = 4'h4;
        md = 16'($urandom());
      end
      drive(vld, a, rv, rt, md, rand_line());
    end
    idle('0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/glm_c0_read_arbiter.md
Name: glm_c0_read_arbiter

Overview:
- Shares the single CCI-P c0 read-request channel among NUM_REQ independent load engines, such as multiple load units running concurrently.
- Grants are round-robin, one request per cycle at most.
- The requester index is tagged into mdata, and each read response is routed back to its originating requester.
- Per-requester outstanding-line credit stops one requester from monopolising the in-flight budget.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LOG2_NUM_REQ, 2, index width; equals ceil(log2(NUM_REQ)).
- MAX_OUTSTANDING, 64, maximum in-flight lines per requester (1..255).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i has a line request pending.
- req_addr  in  NUM_REQ*42  t_ccip_clAddr per requester; slice i is bits [42*i+41 : 42*i].
- req_grant  out  NUM_REQ  one-hot; request i accepted this cycle.
- c0TxAlmFull  in  1  CCI-P c0 TX almost full.
- af2cp_sTx_c0  out  t_if_ccip_c0_Tx  registered read request to the shell.
- cp2af_sRx_c0  in  t_if_ccip_c0_Rx  shell read responses.
- rsp_valid  out  NUM_REQ  one-hot; response data for requester i.
- rsp_data  out  512  response line, shared by all requesters.
- outstanding  out  NUM_REQ*8  in-flight line count per requester.

Behaviour:
- Reset (reset=0, async):
  - req_grant=0, rsp_valid=0, af2cp_sTx_c0.valid=0, af2cp_sTx_c0.hdr=0, rsp_data=0.
  - outstanding=0, round-robin pointer=0.
- Eligibility: requester i is eligible when req_valid[i]=1 and outstanding[i] < MAX_OUTSTANDING.
- Arbitration (combinational grant):
  - Active only when c0TxAlmFull=0.
  - Picks the first eligible index starting at pointer and wrapping modulo NUM_REQ.
  - req_grant is combinational and valid in the same cycle. The requester treats req_valid&req_grant as the handshake and advances its address next cycle.
  - After a grant to i, pointer becomes (i+1) mod NUM_REQ. With no grant, the pointer holds.
- Request issue (registered, 1-cycle latency after the grant):
  - af2cp_sTx_c0.valid=1.
  - hdr.address=req_addr slice of i.
  - hdr.mdata[LOG2_NUM_REQ-1:0]=i; all other hdr fields are 0.
  - Otherwise valid=0 and hdr=0.
- c0TxAlmFull=1: no grant that cycle. A request registered in the previous cycle still issues.
- Response routing (registered, 1-cycle latency):
  - On cci_c0Rx_isReadRsp(cp2af_sRx_c0), set j=mdata[LOG2_NUM_REQ-1:0].
  - Next cycle: rsp_valid[j]=1, rsp_data=cp2af_sRx_c0.data.
- Invalid tag: j >= NUM_REQ raises no rsp_valid and the response is dropped.
- Non-read responses (e.g. UMsg) are ignored.
- Outstanding counters:
  - Increment on grant and decrement on routed response, both in the same clock.
  - A simultaneous grant and response for the same i leaves the count unchanged.
  - Saturation never occurs: grant requires count < MAX_OUTSTANDING.
  - Decrement below 0 is clamped at 0. This is a protocol error; the sim assertion fires.
- Responses are accepted unconditionally: no back-pressure toward the shell. Requesters guarantee buffer space through their own prefetch credit.

Optional Feature:
- Macro: GLM_C0_ARB_STATS_EN.
- Enabled:
  - Adds output stat_grants, NUM_REQ*32, per-requester saturating grant counters.
  - Adds output stat_stall_cycles, 32, counting cycles where some req_valid=1 but no grant occurred.
  - Both clear on reset.
  - Both also clear on input stat_clear (1 bit, synchronous pulse), which is present only with this macro.
- Disabled: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then req_valid=4'b1111, c0TxAlmFull=0 for 8 cycles:
  - Grants are 0,1,2,3,0,1,2,3.
  - af2cp_sTx_c0.valid=1 every cycle, one cycle after each grant.
  - mdata[1:0] matches the granted index.
- Only requester 2 valid, MAX_OUTSTANDING=4, no responses:
  - Exactly 4 grants, then req_grant=0 and outstanding[2]=4.
  - One response with mdata=2 leads to outstanding=3 and a 5th grant the next cycle.
- c0TxAlmFull=1 for 5 cycles with all requesters valid: req_grant=0 and tx valid=0 throughout, except the single request already registered before the stall.
- Read responses arrive with mdata 3,0,1, data A,B,C: rsp_valid is 4'b1000 then 4'b0001 then 4'b0010, each one cycle later, with rsp_data A, B, C.
- Same-cycle grant to 1 and response for 1 while outstanding[1]=5: outstanding[1] stays 5, and the response is delivered.
- Reset asserted mid-burst with 10 lines in flight: all outputs clear immediately (async). Post-reset arbitration starts at pointer 0.
